// File: rtl/tl_tracker_pkg.sv
// Shared TileLink A/D opcodes, slot state/record types and the response-opcode legality check.
// Combinational helpers only; no latency. No flow control, used by a passive monitor.
// Slot address/timestamp fields are sized for the widest supported ADDR_W/TS_W (32).
package tl_tracker_pkg;

  localparam logic [2:0] A_PUT_FULL      = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
  localparam logic [2:0] A_ARITHMETIC    = 3'd2;
  localparam logic [2:0] A_LOGICAL       = 3'd3;
  localparam logic [2:0] A_GET           = 3'd4;
  localparam logic [2:0] A_HINT          = 3'd5;
  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  localparam int unsigned SLOT_ADDR_W = 32;
  localparam int unsigned SLOT_TS_W   = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    TIMEDOUT = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e            state;
    logic [2:0]             opcode;
    logic [SLOT_ADDR_W-1:0] address;
    logic [SLOT_TS_W-1:0]   ts_start;
  } slot_t;

  function automatic logic exp_d_ok(input logic [2:0] a_op, input logic [2:0] d_op);
    logic ok;
    case (a_op)
      A_PUT_FULL, A_PUT_PARTIAL:       ok = (d_op == D_ACCESS_ACK);
      A_ARITHMETIC, A_LOGICAL, A_GET:  ok = (d_op == D_ACCESS_ACK_DATA);
      A_HINT:                          ok = (d_op == D_HINT_ACK);
      default:                         ok = (d_op == D_GRANT) || (d_op == D_GRANT_DATA);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_tracker_slot.sv
// One per-source tracker slot: IDLE/BUSY/TIMEDOUT FSM plus captured opcode, address, start time.
// State updates on the fire edge; event outputs are combinational from the current fires.
// Passive: never stalls A or D, only observes fires.
import tl_tracker_pkg::*;

module tl_tracker_slot #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TS_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TS_W-1:0]   ts_now,
  input  logic              a_fire,
  input  logic [2:0]        a_opcode,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              d_fire,
  output slot_t             slot,
  output logic              retire,
  output logic              dup,
  output logic              orphan,
  output logic              timeout
);

  slot_t            slot_q, slot_d;
  logic             busy;
  logic [TS_W-1:0]  age;
  logic             tmo_hit;

  assign busy    = (slot_q.state != IDLE);
  assign age     = ts_now - slot_q.ts_start[TS_W-1:0];
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (age == TS_W'(TIMEOUT_CYCLES));

  always_comb begin
    slot_d  = slot_q;
    retire  = d_fire & busy;
    orphan  = d_fire & ~busy;
    dup     = a_fire & busy & ~d_fire;
    timeout = (slot_q.state == BUSY) & ~a_fire & ~d_fire & tmo_hit;
    // A allocates even when D retires the old entry (or is an orphan) in the same cycle.
    if (a_fire) begin
      slot_d.state    = BUSY;
      slot_d.opcode   = a_opcode;
      slot_d.address  = SLOT_ADDR_W'(a_address);
      slot_d.ts_start = SLOT_TS_W'(ts_now);
    end else if (retire) begin
      slot_d.state = IDLE;
    end else if (timeout) begin
      slot_d.state = TIMEDOUT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot = slot_q;

endmodule

// File: rtl/tl_txn_tracker.sv
// Per-tile TileLink A/D tracker: matches D to A by source, reports latency, flags anomalies.
// cmp_* registered one cycle after D fire; error flags sticky. Define TL_TRACKER_LOG_EN for logI messages.
// Passive tap: never drives ready/valid, so it applies no backpressure.
import tl_tracker_pkg::*;

module tl_txn_tracker #(
  parameter int unsigned SRC_W          = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TS_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_ready,
  input  logic [2:0]        a_bits_opcode,
  input  logic [SRC_W-1:0]  a_bits_source,
  input  logic [ADDR_W-1:0] a_bits_address,
  input  logic              d_valid,
  input  logic              d_ready,
  input  logic [2:0]        d_bits_opcode,
  input  logic [SRC_W-1:0]  d_bits_source,
  input  logic              d_bits_denied,
  output logic              cmp_valid,
  output logic [SRC_W-1:0]  cmp_source,
  output logic [ADDR_W-1:0] cmp_address,
  output logic [TS_W-1:0]   cmp_latency,
  output logic              cmp_denied,
  output logic [SRC_W:0]    outstanding,
  output logic [TS_W-1:0]   max_latency,
  output logic [TS_W-1:0]   retired_cnt,
  output logic              err_dup,
  output logic              err_orphan,
  output logic              err_opcode,
  output logic              err_timeout
);

  localparam int unsigned NSLOT = 1 << SRC_W;

  logic              a_fire, d_track;
  slot_t             slots [NSLOT];
  logic [NSLOT-1:0]  retire_v, dup_v, orphan_v, timeout_v;
  slot_t             d_slot;
  logic              d_retire;
  logic [TS_W-1:0]   lat;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [SRC_W-1:0]  cmp_source_q, cmp_source_d;
  logic [ADDR_W-1:0] cmp_address_q, cmp_address_d;
  logic [TS_W-1:0]   cmp_latency_q, cmp_latency_d;
  logic              cmp_denied_q, cmp_denied_d;
  logic [TS_W-1:0]   max_latency_q, max_latency_d;
  logic [TS_W-1:0]   retired_cnt_q, retired_cnt_d;
  logic              err_dup_q, err_dup_d;
  logic              err_orphan_q, err_orphan_d;
  logic              err_opcode_q, err_opcode_d;
  logic              err_timeout_q, err_timeout_d;
  logic [SRC_W:0]    busy_cnt;

  assign a_fire  = a_valid & a_ready;
  // ReleaseAck answers the C channel, so it never touches the A/D slots.
  assign d_track = d_valid & d_ready & (d_bits_opcode != D_RELEASE_ACK);

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    tl_tracker_slot #(
      .ADDR_W         (ADDR_W),
      .TS_W           (TS_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_slot (
      .clock     (clock),
      .reset     (reset),
      .ts_now    (ts_q),
      .a_fire    (a_fire && (a_bits_source == SRC_W'(i))),
      .a_opcode  (a_bits_opcode),
      .a_address (a_bits_address),
      .d_fire    (d_track && (d_bits_source == SRC_W'(i))),
      .slot      (slots[i]),
      .retire    (retire_v[i]),
      .dup       (dup_v[i]),
      .orphan    (orphan_v[i]),
      .timeout   (timeout_v[i])
    );
  end

  // At most one D fires per cycle, so the retiring slot is simply the D source.
  assign d_slot   = slots[d_bits_source];
  assign d_retire = |retire_v;
  assign lat      = ts_q - d_slot.ts_start[TS_W-1:0];

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slots[i].state != IDLE) busy_cnt = busy_cnt + {{SRC_W{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    ts_d          = ts_q + TS_W'(1);
    cmp_valid_d   = d_retire;
    cmp_source_d  = cmp_source_q;
    cmp_address_d = cmp_address_q;
    cmp_latency_d = cmp_latency_q;
    cmp_denied_d  = cmp_denied_q;
    max_latency_d = max_latency_q;
    retired_cnt_d = retired_cnt_q;
    if (d_retire) begin
      cmp_source_d  = d_bits_source;
      cmp_address_d = d_slot.address[ADDR_W-1:0];
      cmp_latency_d = lat;
      cmp_denied_d  = d_bits_denied;
      if (lat > max_latency_q) max_latency_d = lat;
      if (retired_cnt_q != {TS_W{1'b1}}) retired_cnt_d = retired_cnt_q + TS_W'(1);
    end
    err_dup_d     = err_dup_q | (|dup_v);
    err_orphan_d  = err_orphan_q | (|orphan_v);
    err_timeout_d = err_timeout_q | (|timeout_v);
    err_opcode_d  = err_opcode_q | (d_retire && !exp_d_ok(d_slot.opcode, d_bits_opcode));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q          <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_source_q  <= '0;
      cmp_address_q <= '0;
      cmp_latency_q <= '0;
      cmp_denied_q  <= 1'b0;
      max_latency_q <= '0;
      retired_cnt_q <= '0;
      err_dup_q     <= 1'b0;
      err_orphan_q  <= 1'b0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      cmp_valid_q   <= cmp_valid_d;
      cmp_source_q  <= cmp_source_d;
      cmp_address_q <= cmp_address_d;
      cmp_latency_q <= cmp_latency_d;
      cmp_denied_q  <= cmp_denied_d;
      max_latency_q <= max_latency_d;
      retired_cnt_q <= retired_cnt_d;
      err_dup_q     <= err_dup_d;
      err_orphan_q  <= err_orphan_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cmp_valid   = cmp_valid_q;
  assign cmp_source  = cmp_source_q;
  assign cmp_address = cmp_address_q;
  assign cmp_latency = cmp_latency_q;
  assign cmp_denied  = cmp_denied_q;
  assign outstanding = busy_cnt;
  assign max_latency = max_latency_q;
  assign retired_cnt = retired_cnt_q;
  assign err_dup     = err_dup_q;
  assign err_orphan  = err_orphan_q;
  assign err_opcode  = err_opcode_q;
  assign err_timeout = err_timeout_q;

`ifdef TL_TRACKER_LOG_EN
`ifndef logI
`define logI(msg) $display("[tl_txn_tracker] I: %s", msg)
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      if (d_retire)
        `logI($sformatf("retire src=%0d addr=0x%0h lat=%0d", d_bits_source, d_slot.address, lat));
      for (int i = 0; i < NSLOT; i++) begin
        if (dup_v[i])     `logI($sformatf("err dup src=%0d", i));
        if (orphan_v[i])  `logI($sformatf("err orphan src=%0d", i));
        if (timeout_v[i]) `logI($sformatf("err timeout src=%0d", i));
      end
      if (d_retire && !exp_d_ok(d_slot.opcode, d_bits_opcode))
        `logI($sformatf("err opcode src=%0d d_op=%0d", d_bits_source, d_bits_opcode));
    end
  end
`endif

endmodule

// File: tb/tb_tl_txn_tracker.sv
// Directed self-checking bench for tl_txn_tracker (TIMEOUT_CYCLES overridden to 50).
module tb_tl_txn_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, a_ready = 1'b1;
  logic [2:0]  a_bits_opcode = '0;
  logic [1:0]  a_bits_source = '0;
  logic [31:0] a_bits_address = '0;
  logic        d_valid = 1'b0, d_ready = 1'b1;
  logic [2:0]  d_bits_opcode = '0;
  logic [1:0]  d_bits_source = '0;
  logic        d_bits_denied = 1'b0;
  logic        cmp_valid, cmp_denied;
  logic [1:0]  cmp_source;
  logic [31:0] cmp_address, cmp_latency, max_latency, retired_cnt;
  logic [2:0]  outstanding;
  logic        err_dup, err_orphan, err_opcode, err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  tl_txn_tracker #(.SRC_W(2), .ADDR_W(32), .TS_W(32), .TIMEOUT_CYCLES(50)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_bits_opcode(a_bits_opcode),
    .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_bits_opcode(d_bits_opcode),
    .d_bits_source(d_bits_source), .d_bits_denied(d_bits_denied),
    .cmp_valid(cmp_valid), .cmp_source(cmp_source), .cmp_address(cmp_address),
    .cmp_latency(cmp_latency), .cmp_denied(cmp_denied), .outstanding(outstanding),
    .max_latency(max_latency), .retired_cnt(retired_cnt),
    .err_dup(err_dup), .err_orphan(err_orphan), .err_opcode(err_opcode),
    .err_timeout(err_timeout)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [1:0] src, input logic [31:0] addr);
    a_valid = 1'b1; a_bits_opcode = op; a_bits_source = src; a_bits_address = addr;
    step();
    a_valid = 1'b0;
  endtask

  task automatic send_d(input logic [2:0] op, input logic [1:0] src, input logic den);
    d_valid = 1'b1; d_bits_opcode = op; d_bits_source = src; d_bits_denied = den;
    step();
    d_valid = 1'b0; d_bits_denied = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if ({cmp_valid, cmp_denied, outstanding, max_latency, retired_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%0b cnt=%0d max=%0d ret=%0d want 0", cmp_valid, outstanding, max_latency, retired_cnt);
    end
    checks++;
    if ({err_dup, err_orphan, err_opcode, err_timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_errs: got %b want 0000", {err_dup, err_orphan, err_opcode, err_timeout});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_get_latency();
    send_a(3'd4, 2'd1, 32'h8000_0000);
    checks++;
    if (outstanding !== 3'd1) begin errors++; $display("FAIL get_outstanding1: got %0d want 1", outstanding); end
    repeat (6) step();
    send_d(3'd1, 2'd1, 1'b0);
    checks++;
    if (cmp_valid !== 1'b1) begin errors++; $display("FAIL get_cmp_valid: got %0b want 1", cmp_valid); end
    checks++;
    if (cmp_latency !== 32'd7) begin errors++; $display("FAIL get_latency: got %0d want 7", cmp_latency); end
    checks++;
    if (cmp_address !== 32'h8000_0000) begin errors++; $display("FAIL get_address: got %h want 80000000", cmp_address); end
    checks++;
    if (cmp_source !== 2'd1) begin errors++; $display("FAIL get_source: got %0d want 1", cmp_source); end
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL get_outstanding0: got %0d want 0", outstanding); end
    checks++;
    if (retired_cnt !== 32'd1 || max_latency !== 32'd7) begin
      errors++; $display("FAIL get_counters: got ret=%0d max=%0d want 1/7", retired_cnt, max_latency);
    end
    step();
    checks++;
    if (cmp_valid !== 1'b0) begin errors++; $display("FAIL get_single_pulse: got %0b want 0", cmp_valid); end
  endtask

  task automatic test_orphan();
    do_reset();
    a_valid = 1'b1; a_ready = 1'b0; a_bits_source = 2'd2;
    step();
    a_valid = 1'b0; a_ready = 1'b1;
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL no_ready_no_fire: got %0d want 0", outstanding); end
    send_d(3'd6, 2'd2, 1'b0);
    checks++;
    if (err_orphan !== 1'b0 || cmp_valid !== 1'b0) begin
      errors++; $display("FAIL releaseack_ignored: got orphan=%0b valid=%0b want 0/0", err_orphan, cmp_valid);
    end
    send_d(3'd0, 2'd2, 1'b0);
    checks++;
    if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got %0b want 1", err_orphan); end
    checks++;
    if (cmp_valid !== 1'b0 || outstanding !== 3'd0) begin
      errors++; $display("FAIL orphan_no_retire: got valid=%0b cnt=%0d want 0/0", cmp_valid, outstanding);
    end
    do_reset();
    a_valid = 1'b1; a_bits_opcode = 3'd4; a_bits_source = 2'd3; a_bits_address = 32'h50;
    d_valid = 1'b1; d_bits_opcode = 3'd1; d_bits_source = 2'd3;
    step();
    a_valid = 1'b0; d_valid = 1'b0;
    checks++;
    if ({err_orphan, err_dup, cmp_valid, outstanding} !== {1'b1, 1'b0, 1'b0, 3'd1}) begin
      errors++; $display("FAIL idle_same_cycle: got orphan=%0b dup=%0b valid=%0b cnt=%0d want 1/0/0/1", err_orphan, err_dup, cmp_valid, outstanding);
    end
  endtask

  task automatic test_opcode();
    do_reset();
    send_a(3'd6, 2'd1, 32'h1000);
    send_d(3'd5, 2'd1, 1'b0);
    checks++;
    if (cmp_valid !== 1'b1 || err_opcode !== 1'b0) begin
      errors++; $display("FAIL acquire_grantdata: got valid=%0b op_err=%0b want 1/0", cmp_valid, err_opcode);
    end
    send_a(3'd5, 2'd2, 32'h2000);
    send_d(3'd2, 2'd2, 1'b0);
    checks++;
    if (cmp_valid !== 1'b1 || err_opcode !== 1'b0) begin
      errors++; $display("FAIL hint_hintack: got valid=%0b op_err=%0b want 1/0", cmp_valid, err_opcode);
    end
    send_a(3'd4, 2'd0, 32'h40);
    send_d(3'd0, 2'd0, 1'b0);
    checks++;
    if (cmp_valid !== 1'b1 || err_opcode !== 1'b1 || outstanding !== 3'd0) begin
      errors++; $display("FAIL get_accessack: got valid=%0b op_err=%0b cnt=%0d want 1/1/0", cmp_valid, err_opcode, outstanding);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int s = 0; s < 4; s++) send_a(3'd0, 2'(s), 32'h100 + 32'(s) * 4);
    checks++;
    if (outstanding !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d want 4", outstanding); end
    a_valid = 1'b1; a_bits_opcode = 3'd0; a_bits_source = 2'd0; a_bits_address = 32'h200;
    d_valid = 1'b1; d_bits_opcode = 3'd0; d_bits_source = 2'd0;
    step();
    a_valid = 1'b0; d_valid = 1'b0;
    checks++;
    if (outstanding !== 3'd4 || err_dup !== 1'b0) begin
      errors++; $display("FAIL b2b_same_cycle: got cnt=%0d dup=%0b want 4/0", outstanding, err_dup);
    end
    checks++;
    if (cmp_valid !== 1'b1 || cmp_source !== 2'd0 || cmp_address !== 32'h100) begin
      errors++; $display("FAIL b2b_retire_old: got valid=%0b src=%0d addr=%h want 1/0/100", cmp_valid, cmp_source, cmp_address);
    end
    send_a(3'd0, 2'd1, 32'h300);
    checks++;
    if (err_dup !== 1'b1 || outstanding !== 3'd4) begin
      errors++; $display("FAIL dup_flag: got dup=%0b cnt=%0d want 1/4", err_dup, outstanding);
    end
    send_d(3'd0, 2'd1, 1'b0);
    checks++;
    if (cmp_address !== 32'h300) begin errors++; $display("FAIL dup_overwrite: got %h want 300", cmp_address); end
    send_d(3'd0, 2'd2, 1'b1);
    checks++;
    if (cmp_denied !== 1'b1 || cmp_source !== 2'd2 || outstanding !== 3'd2 || retired_cnt !== 32'd3) begin
      errors++; $display("FAIL denied_retire: got den=%0b src=%0d cnt=%0d ret=%0d want 1/2/2/3", cmp_denied, cmp_source, outstanding, retired_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_a(3'd4, 2'd3, 32'hABC0);
    repeat (49) step();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b want 0 at age 49", err_timeout); end
    step();
    checks++;
    if (err_timeout !== 1'b1 || outstanding !== 3'd1) begin
      errors++; $display("FAIL timeout_at_50: got tmo=%0b cnt=%0d want 1/1", err_timeout, outstanding);
    end
    repeat (9) step();
    send_d(3'd1, 2'd3, 1'b0);
    checks++;
    if (cmp_valid !== 1'b1 || cmp_latency !== 32'd60 || outstanding !== 3'd0 || max_latency !== 32'd60) begin
      errors++; $display("FAIL timeout_late_retire: got valid=%0b lat=%0d cnt=%0d max=%0d want 1/60/0/60", cmp_valid, cmp_latency, outstanding, max_latency);
    end
  endtask

  task automatic test_reset_midflight();
    send_a(3'd4, 2'd0, 32'h10);
    send_a(3'd4, 2'd1, 32'h20);
    checks++;
    if (outstanding !== 3'd2) begin errors++; $display("FAIL mid_inflight: got %0d want 2", outstanding); end
    reset = 1'b0;
    #1;
    checks++;
    if ({cmp_valid, outstanding, max_latency, retired_cnt, err_timeout} !== '0) begin
      errors++; $display("FAIL mid_async_clear: got cnt=%0d max=%0d ret=%0d tmo=%0b want 0", outstanding, max_latency, retired_cnt, err_timeout);
    end
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cmp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_cmp[%0d]: got %0b want 0", i, cmp_valid); end
    end
    send_d(3'd1, 2'd0, 1'b0);
    checks++;
    if (err_orphan !== 1'b1 || cmp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_late_d: got orphan=%0b valid=%0b want 1/0", err_orphan, cmp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_get_latency();
    test_orphan();
    test_opcode();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
